load_store_unit: RTL and testbench

// Executes one memory op at a time for the load/store buffer (LSB), the responder end of the LSB->LSU request interface.

---
 rtl/load_store_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Executes one memory operation at a time on behalf of the load/store buffer.
// A request is latched, the byte-wide RAM port is requested from the memory
// arbiter, and 1/2/4 bytes are moved little-endian, one byte per granted cycle.
// Load results are sign- or zero-extended and broadcast with their ROB id for
// one cycle. Stores never report a result.
//
// Instruction codes (inst_name_from_lsb), shared with the LSB decoder:
//   1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW
//
// Ports
//   clk_in                 in   1      clock, rising edge
//   rst_in                 in   1      asynchronous active-low reset
//   rdy_in                 in   1      global stall when low
//   en_signal_from_lsb     in   1      request valid (one-cycle pulse)
//   inst_name_from_lsb     in   6      operation code
//   mem_addr_from_lsb      in   32     byte address
//   store_value_from_lsb   in   32     store data (low bytes used)
//   rob_id_from_lsb        in   ROB_W  destination ROB id
//   busy_to_lsb            out  1      cannot accept a request this cycle
//   valid_out              out  1      load result valid (one-cycle pulse)
//   result_out             out  32     extended load data
//   rob_id_out             out  ROB_W  ROB id of the result
//   rollback_flag_from_rob in   1      squash speculative work
//   mem_req_out            out  1      request the RAM port
//   mem_grant_in           in   1      arbiter grants the port
//   mem_a_out              out  32     RAM byte address
//   mem_dout_out           out  8      RAM write byte
//   mem_wr_out             out  1      1 = write, 0 = read
//   mem_din_in             in   8      RAM read byte, 1-cycle latency
//   io_buffer_full_in      in   1      UART buffer full
//
// Port grant and IO back-pressure are sampled at the clock edge and decide
// whether the following ACCESS cycle moves a byte; that decision is held in
// xfer_q so mem_wr_out can come straight from a flop.
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter logic [31:0] IO_ADDR = 32'h0003_0000,
   parameter int          ROB_W   = 5
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             en_signal_from_lsb,
   input  logic [5:0]       inst_name_from_lsb,
   input  logic [31:0]      mem_addr_from_lsb,
   input  logic [31:0]      store_value_from_lsb,
   input  logic [ROB_W-1:0] rob_id_from_lsb,
   output logic             busy_to_lsb,
   output logic             valid_out,
   output logic [31:0]      result_out,
   output logic [ROB_W-1:0] rob_id_out,
   input  logic             rollback_flag_from_rob,
   output logic             mem_req_out,
   input  logic             mem_grant_in,
   output logic [31:0]      mem_a_out,
   output logic [7:0]       mem_dout_out,
   output logic             mem_wr_out,
   input  logic [7:0]       mem_din_in,
   input  logic             io_buffer_full_in
);

   localparam logic [5:0] INST_LB  = 6'd1;
   localparam logic [5:0] INST_LH  = 6'd2;
   localparam logic [5:0] INST_LW  = 6'd3;
   localparam logic [5:0] INST_LBU = 6'd4;
   localparam logic [5:0] INST_LHU = 6'd5;
   localparam logic [5:0] INST_SB  = 6'd6;
   localparam logic [5:0] INST_SH  = 6'd7;
   localparam logic [5:0] INST_SW  = 6'd8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ACCESS,
      S_WAIT,
      S_DONE
   } state_e;

   function automatic logic is_store(input logic [5:0] code);
      return code inside {INST_SB, INST_SH, INST_SW};
   endfunction

   // Index of the last byte of the access: 0, 1 or 3.
   function automatic logic [1:0] last_byte(input logic [5:0] code);
      case (code)
         INST_LB, INST_LBU, INST_SB: return 2'd0;
         INST_LH, INST_LHU, INST_SH: return 2'd1;
         default:                    return 2'd3;
      endcase
   endfunction

   state_e           state_q, state_d;
   logic [5:0]       inst_q;
   logic [31:0]      addr_q;
   logic [31:0]      value_q;
   logic [31:0]      data_q;
   logic [ROB_W-1:0] rob_q;
   logic [1:0]       k_q, k_d;
   logic [1:0]       cap_k_q;
   logic             cap_q, cap_d;
   logic             xfer_q, xfer_d;
   logic             mem_wr_q, mem_wr_d;
   logic             mem_req_q, mem_req_d;
   logic             valid_q, valid_d;
   logic             take;
   logic             store_q;
   logic             abort;
   logic             io_hold;
   logic [31:0]      result_ext;

   assign store_q = is_store(inst_q);
   // Only speculative work is squashed; a store here is already committed.
   assign abort   = rollback_flag_from_rob && !store_q && (state_q != S_IDLE);

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      take    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // A load arriving with a rollback is itself speculative: drop it.
            if (en_signal_from_lsb &&
                (!rollback_flag_from_rob || is_store(inst_name_from_lsb))) begin
               take    = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (mem_grant_in) begin
               state_d = S_ACCESS;
               k_d     = 2'd0;
            end
         end
         S_ACCESS: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (xfer_q) begin
               if (k_q == last_byte(inst_q)) begin
                  state_d = store_q ? S_IDLE : S_WAIT;
               end else begin
                  k_d = k_q + 2'd1;
               end
            end
         end
         S_WAIT:  state_d = abort ? S_IDLE : S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // The UART byte is held back while its buffer is full.
      io_hold   = store_q && ((addr_q + 32'(k_d)) == IO_ADDR) && io_buffer_full_in;
      xfer_d    = (state_d == S_ACCESS) && mem_grant_in && !io_hold;
      mem_wr_d  = xfer_d && store_q;
      mem_req_d = (state_d == S_REQ) || (state_d == S_ACCESS);
      valid_d   = (state_d == S_DONE);
      // Read data arrives one cycle after the address, so capture is deferred.
      cap_d     = (state_q == S_ACCESS) && xfer_q && !store_q && (state_d != S_IDLE);
   end

   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples the pre-edge values of the others.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_IDLE;
      end else if (rdy_in) begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         inst_q    <= '0;
         addr_q    <= '0;
         value_q   <= '0;
         data_q    <= '0;
         rob_q     <= '0;
         k_q       <= '0;
         cap_k_q   <= '0;
         cap_q     <= 1'b0;
         xfer_q    <= 1'b0;
         mem_wr_q  <= 1'b0;
         mem_req_q <= 1'b0;
         valid_q   <= 1'b0;
      end else if (rdy_in) begin
         k_q       <= k_d;
         cap_k_q   <= k_q;
         cap_q     <= cap_d;
         xfer_q    <= xfer_d;
         mem_wr_q  <= mem_wr_d;
         mem_req_q <= mem_req_d;
         valid_q   <= valid_d;
         if (take) begin
            inst_q  <= inst_name_from_lsb;
            addr_q  <= mem_addr_from_lsb;
            value_q <= store_value_from_lsb;
            rob_q   <= rob_id_from_lsb;
            data_q  <= '0;
         end else if (cap_q) begin
            data_q[{cap_k_q, 3'b000} +: 8] <= mem_din_in;
         end
      end
   end

   always_comb begin
      result_ext = data_q;
      case (inst_q)
         INST_LB:  result_ext = {{24{data_q[7]}}, data_q[7:0]};
         INST_LH:  result_ext = {{16{data_q[15]}}, data_q[15:0]};
         INST_LBU: result_ext = {24'h0, data_q[7:0]};
         INST_LHU: result_ext = {16'h0, data_q[15:0]};
         default:  result_ext = data_q;
      endcase
   end

   assign busy_to_lsb  = en_signal_from_lsb || (state_q != S_IDLE);
   assign valid_out    = valid_q;
   assign result_out   = result_ext;
   assign rob_id_out   = rob_q;
   assign mem_req_out  = mem_req_q;
   // A stalled cycle must never reach the RAM as a write.
   assign mem_wr_out   = mem_wr_q && rdy_in;
   assign mem_a_out    = addr_q + 32'(k_q);
   assign mem_dout_out = value_q[{k_q, 3'b000} +: 8];

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit: a table of load/store vectors with
// hand-computed results and latencies, followed by hand-written sequences for
// IO back-pressure, rollback, grant loss, held enable and global stall.
// Cycle numbers are relative to the cycle T in which the request is presented
// (rel 0); outputs are sampled 2 time units after each rising edge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   localparam logic [5:0] LB  = 6'd1;
   localparam logic [5:0] LH  = 6'd2;
   localparam logic [5:0] LW  = 6'd3;
   localparam logic [5:0] LBU = 6'd4;
   localparam logic [5:0] LHU = 6'd5;
   localparam logic [5:0] SB  = 6'd6;
   localparam logic [5:0] SH  = 6'd7;
   localparam logic [5:0] SW  = 6'd8;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        en_signal_from_lsb;
   logic [5:0]  inst_name_from_lsb;
   logic [31:0] mem_addr_from_lsb;
   logic [31:0] store_value_from_lsb;
   logic [4:0]  rob_id_from_lsb;
   logic        busy_to_lsb;
   logic        valid_out;
   logic [31:0] result_out;
   logic [4:0]  rob_id_out;
   logic        rollback_flag_from_rob;
   logic        mem_req_out;
   logic        mem_grant_in;
   logic [31:0] mem_a_out;
   logic [7:0]  mem_dout_out;
   logic        mem_wr_out;
   logic [7:0]  mem_din_in;
   logic        io_buffer_full_in;

   load_store_unit #(.IO_ADDR(32'h0003_0000), .ROB_W(5)) dut (
      .clk_in                 (clk_in),
      .rst_in                 (rst_in),
      .rdy_in                 (rdy_in),
      .en_signal_from_lsb     (en_signal_from_lsb),
      .inst_name_from_lsb     (inst_name_from_lsb),
      .mem_addr_from_lsb      (mem_addr_from_lsb),
      .store_value_from_lsb   (store_value_from_lsb),
      .rob_id_from_lsb        (rob_id_from_lsb),
      .busy_to_lsb            (busy_to_lsb),
      .valid_out              (valid_out),
      .result_out             (result_out),
      .rob_id_out             (rob_id_out),
      .rollback_flag_from_rob (rollback_flag_from_rob),
      .mem_req_out            (mem_req_out),
      .mem_grant_in           (mem_grant_in),
      .mem_a_out              (mem_a_out),
      .mem_dout_out           (mem_dout_out),
      .mem_wr_out             (mem_wr_out),
      .mem_din_in             (mem_din_in),
      .io_buffer_full_in      (io_buffer_full_in)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // ---------------- RAM model: byte-wide, 1-cycle read latency -------------
   logic [7:0]  ram [logic [31:0]];
   logic        pre_we;
   logic [31:0] pre_addr;
   logic [31:0] pre_word;

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : 8'h00;
   endfunction

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return {ram_rd(a + 32'd3), ram_rd(a + 32'd2), ram_rd(a + 32'd1), ram_rd(a)};
   endfunction

   always @(posedge clk_in) begin
      if (pre_we) begin
         for (int k = 0; k < 4; k++) ram[pre_addr + 32'(k)] = pre_word[8*k +: 8];
      end else if (mem_wr_out) begin
         ram[mem_a_out] = mem_dout_out;
      end
      mem_din_in <= ram_rd(mem_a_out);
   end

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] w);
      pre_addr = a;
      pre_word = w;
      pre_we   = 1'b1;
      tick();
      pre_we   = 1'b0;
   endtask

   task automatic issue(input logic [5:0] inst, input logic [31:0] a,
                        input logic [31:0] val, input logic [4:0] rob);
      inst_name_from_lsb   = inst;
      mem_addr_from_lsb    = a;
      store_value_from_lsb = val;
      rob_id_from_lsb      = rob;
      en_signal_from_lsb   = 1'b1;
   endtask

   typedef struct {
      logic [5:0]  inst;
      logic [31:0] addr;
      logic [31:0] value;
      logic [4:0]  rob;
      logic [31:0] pre;      // RAM bytes at addr..addr+3 before the op
      logic [31:0] exp_res;  // load: result_out; store: RAM word afterwards
      int          exp_cyc;  // load: valid_out cycle; store: first busy-low cycle
      bit          store;
   } vec_t;

   vec_t vecs [10];

   // Issue one op with grant high and watch 30 cycles.
   task automatic run_op(input vec_t v, output int valid_rel, output int nvalid,
                         output logic [31:0] res, output logic [4:0] rid,
                         output int idle_rel);
      issue(v.inst, v.addr, v.value, v.rob);
      tick();
      en_signal_from_lsb = 1'b0;
      valid_rel = -1;
      idle_rel  = -1;
      nvalid    = 0;
      res       = '0;
      rid       = '0;
      for (int rel = 1; rel <= 30; rel++) begin
         #1;
         if (valid_out) begin
            nvalid++;
            if (valid_rel < 0) begin
               valid_rel = rel;
               res       = result_out;
               rid       = rob_id_out;
            end
         end
         if (!busy_to_lsb && idle_rel < 0) idle_rel = rel;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          valid_rel, nvalid, idle_rel;
      logic [31:0] res;
      logic [4:0]  rid;
      logic [15:0] wr_mask, req_mask;
      logic        busy_s, req_s;

      rst_in = 1'b0; rdy_in = 1'b1; en_signal_from_lsb = 1'b0;
      inst_name_from_lsb = '0; mem_addr_from_lsb = '0; store_value_from_lsb = '0;
      rob_id_from_lsb = '0; rollback_flag_from_rob = 1'b0; mem_grant_in = 1'b1;
      io_buffer_full_in = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_word = '0;

      // ---------------- reset state ----------------
      repeat (3) tick();
      #1;
      check("reset valid_out",   32'(valid_out),   32'd0);
      check("reset busy",        32'(busy_to_lsb), 32'd0);
      check("reset mem_req_out", 32'(mem_req_out), 32'd0);
      check("reset mem_wr_out",  32'(mem_wr_out),  32'd0);
      check("reset result_out",  result_out,       32'd0);
      check("reset rob_id_out",  32'(rob_id_out),  32'd0);
      check("reset mem_a_out",   mem_a_out,        32'd0);
      rst_in = 1'b1;
      tick();

      // ---------------- table-driven vectors ----------------
      vecs[0] = '{LW,  32'h0000_0100, 32'h0,         5'd7,  32'h1234_5678, 32'h1234_5678, 7, 1'b0};
      vecs[1] = '{LB,  32'h0000_0200, 32'h0,         5'd1,  32'h0000_0080, 32'hFFFF_FF80, 4, 1'b0};
      vecs[2] = '{LBU, 32'h0000_0200, 32'h0,         5'd2,  32'h0000_0080, 32'h0000_0080, 4, 1'b0};
      vecs[3] = '{LHU, 32'h0000_0300, 32'h0,         5'd3,  32'h0000_FFFE, 32'h0000_FFFE, 5, 1'b0};
      vecs[4] = '{LH,  32'h0000_0300, 32'h0,         5'd4,  32'h0000_FFFE, 32'hFFFF_FFFE, 5, 1'b0};
      vecs[5] = '{LW,  32'hFFFF_FFFE, 32'h0,         5'd31, 32'h4433_2211, 32'h4433_2211, 7, 1'b0};
      vecs[6] = '{LH,  32'h0000_0403, 32'h0,         5'd5,  32'h0000_7F01, 32'h0000_7F01, 5, 1'b0};
      vecs[7] = '{SH,  32'h0000_0010, 32'hAABB_CCDD, 5'd6,  32'h5A5A_5A5A, 32'h5A5A_CCDD, 4, 1'b1};
      vecs[8] = '{SW,  32'h0000_0020, 32'h0102_0304, 5'd8,  32'h5A5A_5A5A, 32'h0102_0304, 6, 1'b1};
      vecs[9] = '{SB,  32'h0000_0041, 32'h0000_00EF, 5'd9,  32'h5A5A_5A5A, 32'h5A5A_5AEF, 3, 1'b1};

      for (int i = 0; i < 10; i++) begin
         preload(vecs[i].addr, vecs[i].pre);
         run_op(vecs[i], valid_rel, nvalid, res, rid, idle_rel);
         if (vecs[i].store) begin
            check($sformatf("vec%0d store ram word", i), ram_word(vecs[i].addr), vecs[i].exp_res);
            check($sformatf("vec%0d store busy-low cycle", i), 32'(idle_rel), 32'(vecs[i].exp_cyc));
            check($sformatf("vec%0d store valid count", i), 32'(nvalid), 32'd0);
         end else begin
            check($sformatf("vec%0d load valid cycle", i), 32'(valid_rel), 32'(vecs[i].exp_cyc));
            check($sformatf("vec%0d load result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d load rob id", i), 32'(rid), 32'(vecs[i].rob));
            check($sformatf("vec%0d load valid count", i), 32'(nvalid), 32'd1);
         end
      end

      // ---------------- SB to IO address with UART buffer full ----------------
      // Buffer full sampled at the edges ending rel 1..3 holds back rel 2..4.
      preload(32'h0003_0000, 32'h0);
      issue(SB, 32'h0003_0000, 32'h0000_0041, 5'd0);
      tick();
      en_signal_from_lsb = 1'b0;
      wr_mask = '0; req_mask = '0; idle_rel = -1;
      for (int rel = 1; rel <= 15; rel++) begin
         io_buffer_full_in = (rel <= 3);
         #1;
         wr_mask[rel]  = mem_wr_out;
         req_mask[rel] = mem_req_out;
         if (!busy_to_lsb && idle_rel < 0) idle_rel = rel;
         tick();
      end
      io_buffer_full_in = 1'b0;
      check("io write cycles",   32'(wr_mask),  32'h0000_0020);
      check("io req cycles",     32'(req_mask), 32'h0000_003E);
      check("io busy-low cycle", 32'(idle_rel), 32'd6);
      check("io byte written",   32'(ram_rd(32'h0003_0000)), 32'h41);

      // ---------------- LW rolled back in ACCESS k=2 ----------------
      preload(32'h0000_0100, 32'h1234_5678);
      issue(LW, 32'h0000_0100, 32'h0, 5'd9);
      tick();
      en_signal_from_lsb = 1'b0;
      nvalid = 0; busy_s = 1'b1; req_s = 1'b1;
      for (int rel = 1; rel <= 12; rel++) begin
         rollback_flag_from_rob = (rel == 4);
         #1;
         if (valid_out) nvalid++;
         if (rel == 5) begin
            busy_s = busy_to_lsb;
            req_s  = mem_req_out;
         end
         tick();
      end
      rollback_flag_from_rob = 1'b0;
      check("lw rollback busy next cycle",    32'(busy_s), 32'd0);
      check("lw rollback mem_req next cycle", 32'(req_s),  32'd0);
      check("lw rollback valid count",        32'(nvalid), 32'd0);

      // ---------------- SW in progress ignores rollback ----------------
      preload(32'h0000_0050, 32'h0);
      issue(SW, 32'h0000_0050, 32'hCAFE_BABE, 5'd10);
      tick();
      en_signal_from_lsb = 1'b0;
      nvalid = 0; idle_rel = -1;
      for (int rel = 1; rel <= 12; rel++) begin
         rollback_flag_from_rob = (rel == 3);
         #1;
         if (valid_out) nvalid++;
         if (!busy_to_lsb && idle_rel < 0) idle_rel = rel;
         tick();
      end
      rollback_flag_from_rob = 1'b0;
      check("sw rollback ram word",   ram_word(32'h0000_0050), 32'hCAFE_BABE);
      check("sw rollback busy-low",   32'(idle_rel), 32'd6);
      check("sw rollback valid count", 32'(nvalid), 32'd0);

      // ---------------- request in the rollback cycle ----------------
      rollback_flag_from_rob = 1'b1;
      issue(LW, 32'h0000_0100, 32'h0, 5'd11);
      tick();
      en_signal_from_lsb = 1'b0;
      rollback_flag_from_rob = 1'b0;
      #1;
      check("load in rollback cycle dropped (busy)", 32'(busy_to_lsb), 32'd0);
      check("load in rollback cycle dropped (req)",  32'(mem_req_out), 32'd0);
      nvalid = 0;
      for (int rel = 2; rel <= 10; rel++) begin
         tick();
         #1;
         if (valid_out) nvalid++;
      end
      tick();
      check("load in rollback cycle valid count", 32'(nvalid), 32'd0);

      preload(32'h0000_0090, 32'h0);
      rollback_flag_from_rob = 1'b1;
      issue(SB, 32'h0000_0090, 32'h0000_00A5, 5'd12);
      tick();
      en_signal_from_lsb = 1'b0;
      rollback_flag_from_rob = 1'b0;
      idle_rel = -1;
      for (int rel = 1; rel <= 10; rel++) begin
         #1;
         if (!busy_to_lsb && idle_rel < 0) idle_rel = rel;
         tick();
      end
      check("store in rollback cycle busy-low", 32'(idle_rel), 32'd3);
      check("store in rollback cycle byte",     32'(ram_rd(32'h0000_0090)), 32'hA5);

      // ---------------- grant low for 5 cycles after request ----------------
      preload(32'h0000_0060, 32'h0);
      issue(SB, 32'h0000_0060, 32'h0000_0077, 5'd13);
      tick();
      en_signal_from_lsb = 1'b0;
      wr_mask = '0; req_mask = '0; idle_rel = -1;
      for (int rel = 1; rel <= 15; rel++) begin
         mem_grant_in = (rel > 5);
         #1;
         wr_mask[rel]  = mem_wr_out;
         req_mask[rel] = mem_req_out;
         if (!busy_to_lsb && idle_rel < 0) idle_rel = rel;
         tick();
      end
      mem_grant_in = 1'b1;
      check("grant-late req cycles",   32'(req_mask), 32'h0000_00FE);
      check("grant-late write cycles", 32'(wr_mask),  32'h0000_0080);
      check("grant-late busy-low",     32'(idle_rel), 32'd8);
      check("grant-late byte",         32'(ram_rd(32'h0000_0060)), 32'h77);

      // ---------------- grant withdrawn mid-ACCESS ----------------
      preload(32'h0000_0070, 32'h5A5A_5A5A);
      issue(SH, 32'h0000_0070, 32'h0000_1234, 5'd14);
      tick();
      en_signal_from_lsb = 1'b0;
      wr_mask = '0; req_mask = '0; idle_rel = -1;
      for (int rel = 1; rel <= 12; rel++) begin
         mem_grant_in = (rel != 2);
         #1;
         wr_mask[rel]  = mem_wr_out;
         req_mask[rel] = mem_req_out;
         if (!busy_to_lsb && idle_rel < 0) idle_rel = rel;
         tick();
      end
      mem_grant_in = 1'b1;
      check("grant-drop write cycles", 32'(wr_mask),  32'h0000_0014);
      check("grant-drop req cycles",   32'(req_mask), 32'h0000_001E);
      check("grant-drop busy-low",     32'(idle_rel), 32'd5);
      check("grant-drop ram word",     ram_word(32'h0000_0070), 32'h5A5A_1234);

      // ---------------- enable held while busy ----------------
      preload(32'h0000_0200, 32'h0000_0080);
      issue(LB, 32'h0000_0200, 32'h0, 5'd3);
      #1;
      check("busy follows en while idle", 32'(busy_to_lsb), 32'd1);
      tick();
      rob_id_from_lsb = 5'd9;
      #1;
      check("busy in REQ with en held", 32'(busy_to_lsb), 32'd1);
      tick();
      en_signal_from_lsb = 1'b0;
      nvalid = 0; valid_rel = -1; rid = '0; res = '0;
      for (int rel = 2; rel <= 15; rel++) begin
         #1;
         if (valid_out) begin
            nvalid++;
            if (valid_rel < 0) begin
               valid_rel = rel;
               rid       = rob_id_out;
               res       = result_out;
            end
         end
         tick();
      end
      check("held-en valid count", 32'(nvalid),    32'd1);
      check("held-en valid cycle", 32'(valid_rel), 32'd4);
      check("held-en rob id",      32'(rid),       32'd3);
      check("held-en result",      res,            32'hFFFF_FF80);

      // ---------------- global stall during a SW ----------------
      preload(32'h0000_0080, 32'h0);
      issue(SW, 32'h0000_0080, 32'h1122_3344, 5'd15);
      tick();
      en_signal_from_lsb = 1'b0;
      wr_mask = '0; idle_rel = -1;
      for (int rel = 1; rel <= 15; rel++) begin
         rdy_in = (rel != 3);
         #1;
         wr_mask[rel] = mem_wr_out;
         if (!busy_to_lsb && idle_rel < 0) idle_rel = rel;
         tick();
      end
      rdy_in = 1'b1;
      check("stall write cycles", 32'(wr_mask),  32'h0000_0074);
      check("stall busy-low",     32'(idle_rel), 32'd7);
      check("stall ram word",     ram_word(32'h0000_0080), 32'h1122_3344);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
